// File: rtl/sitcpxg_tx_arbiter_if.sv
// Bus bundle between the two block requesters, the arbiter and the SiTCPXG
// TX port. The master modport is the arbiter side. The slave modport is the
// environment side: the requesters and SiTCPXG.
interface sitcpxg_tx_arbiter_if;
    // SiTCPXG side
    logic        SiTCPXG_ESTABLISHED;
    logic        SiTCPXG_TX_AFULL;
    logic [63:0] SiTCPXG_TX_D;
    logic [3:0]  SiTCPXG_TX_B;

    // requester 0
    logic        REQ0;
    logic [15:0] LEN0;
    logic [63:0] D0;
    logic [3:0]  B0;
    logic        GNT0;
    logic        RD0;
    logic        DONE0;
    logic        ABORT0;

    // requester 1
    logic        REQ1;
    logic [15:0] LEN1;
    logic [63:0] D1;
    logic [3:0]  B1;
    logic        GNT1;
    logic        RD1;
    logic        DONE1;
    logic        ABORT1;

    // status
    logic        BUSY;
    logic        ACTIVE_CH;

    modport master (
        input  SiTCPXG_ESTABLISHED, SiTCPXG_TX_AFULL,
        input  REQ0, LEN0, D0, B0,
        input  REQ1, LEN1, D1, B1,
        output SiTCPXG_TX_D, SiTCPXG_TX_B,
        output GNT0, RD0, DONE0, ABORT0,
        output GNT1, RD1, DONE1, ABORT1,
        output BUSY, ACTIVE_CH
    );

    modport slave (
        output SiTCPXG_ESTABLISHED, SiTCPXG_TX_AFULL,
        output REQ0, LEN0, D0, B0,
        output REQ1, LEN1, D1, B1,
        input  SiTCPXG_TX_D, SiTCPXG_TX_B,
        input  GNT0, RD0, DONE0, ABORT0,
        input  GNT1, RD1, DONE1, ABORT1,
        input  BUSY, ACTIVE_CH
    );
endinterface

// File: rtl/sitcpxg_tx_arbiter.sv
// Two-channel, block-granular round-robin arbiter that feeds the SiTCPXG TX
// port.
//
// Each requester owns its channel for a whole block of LENn words. The word
// counter is loaded in the grant cycle, so reading starts on the following
// cycle. The counter reaches zero on the last read. The next cycle pulses
// DONE, and the FSM then leaves XFER. A lost TCP session ends the block with
// an ABORT pulse.
module sitcpxg_tx_arbiter #(
    parameter int IDLE_GAP = 1            // idle cycles between blocks, 0..15
) (
    input  logic                        CLK156M,
    input  logic                        RSTs,
    sitcpxg_tx_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The gap timer counts down to zero, so it is loaded with IDLE_GAP-1.
    localparam logic [3:0] GAP_INIT = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    state_t      state;
    logic [15:0] cnt;          // words still to read in the current block
    logic [3:0]  gap_cnt;
    logic        ch;           // owner of the current or most recent block
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic [1:0]  abort_q;
    logic [63:0] tx_d;
    logic [3:0]  tx_b;

    logic        rd_en;
    logic        grant_ch;
    logic [15:0] sel_len;
    logic [63:0] sel_d;
    logic [3:0]  sel_b;

    // Select the owning channel's data, pick the next winner, and qualify the read strobe.
    always_comb begin
        sel_len = ch ? bus.LEN1 : bus.LEN0;
        sel_d   = ch ? bus.D1   : bus.D0;
        sel_b   = ch ? bus.B1   : bus.B0;

        // Contention goes to the channel that was not served last. Otherwise the
        // single requester wins.
        grant_ch = 1'b0;
        if (bus.REQ0 && bus.REQ1)
            grant_ch = ~ch;
        else if (bus.REQ1)
            grant_ch = 1'b1;

        // Reading is not allowed in the grant cycle, because the counter is
        // still zero there. It is also not allowed while reset is applied, so
        // that a word is not popped from a block that reset is discarding.
        rd_en = (state == ST_XFER) && bus.SiTCPXG_ESTABLISHED &&
                !bus.SiTCPXG_TX_AFULL && (cnt != 16'd0) && !RSTs;
    end

    // Block FSM: grant in IDLE, count words in XFER, hold off in GAP; pulses registered.
    always_ff @(posedge CLK156M) begin
        if (RSTs) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            gap_cnt <= 4'd0;
            ch      <= 1'b1;      // channel 0 wins the first contention
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            abort_q <= 2'b00;
        end else begin
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            abort_q <= 2'b00;

            case (state)
                ST_IDLE: begin
                    if (bus.SiTCPXG_ESTABLISHED && (bus.REQ0 || bus.REQ1)) begin
                        state           <= ST_XFER;
                        ch              <= grant_ch;
                        gnt_q[grant_ch] <= 1'b1;
                    end
                end

                ST_XFER: begin
                    if (gnt_q != 2'b00) begin
                        // Grant cycle: the requester still holds LEN valid.
                        if (!bus.SiTCPXG_ESTABLISHED) begin
                            abort_q[ch] <= 1'b1;
                            state       <= ST_IDLE;
                            cnt         <= 16'd0;
                        end else begin
                            cnt <= sel_len;
                            if (sel_len == 16'd0)
                                done_q[ch] <= 1'b1;
                        end
                    end else if (done_q != 2'b00) begin
                        // DONE is showing this cycle, so the block is finished.
                        cnt     <= 16'd0;
                        gap_cnt <= GAP_INIT;
                        state   <= (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
                    end else if (!bus.SiTCPXG_ESTABLISHED) begin
                        abort_q[ch] <= 1'b1;
                        state       <= ST_IDLE;
                        cnt         <= 16'd0;
                    end else if (rd_en) begin
                        cnt <= cnt - 16'd1;
                        if (cnt == 16'd1)
                            done_q[ch] <= 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // The TX word is registered one cycle after the read. A cycle without a read sends zero.
    always_ff @(posedge CLK156M) begin
        if (RSTs) begin
            tx_d <= 64'd0;
            tx_b <= 4'd0;
        end else if (rd_en) begin
            tx_d <= sel_d;
            tx_b <= sel_b;
        end else begin
            tx_d <= 64'd0;
            tx_b <= 4'd0;
        end
    end

    assign bus.SiTCPXG_TX_D = tx_d;
    assign bus.SiTCPXG_TX_B = tx_b;
    assign bus.GNT0         = gnt_q[0];
    assign bus.GNT1         = gnt_q[1];
    assign bus.RD0          = rd_en & ~ch;
    assign bus.RD1          = rd_en & ch;
    assign bus.DONE0        = done_q[0];
    assign bus.DONE1        = done_q[1];
    assign bus.ABORT0       = abort_q[0];
    assign bus.ABORT1       = abort_q[1];
    assign bus.BUSY         = (state != ST_IDLE);
    assign bus.ACTIVE_CH    = ch;

endmodule
